// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared opcodes, segment width helper and stage control record
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits resolved per pipeline stage; guarded so a bad STAGES still elaborates to the check.
    function automatic int seg_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // Control part of a stage record. The width-dependent parts (a_hi, bb_hi, sum_lo)
    // travel next to it as full-width vectors in the top level; each stage only
    // consumes the upper slices of a/bb and only fills the lower slices of sum.
    typedef struct packed {
        logic valid;
        logic a_sign;
        logic sat;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - W-bit slice adder with carry out and carry into the slice MSB
module addsub_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s     = full[W-1:0];
    assign cout  = full[W];
    // Carry into the MSB recovered from the MSB sum bit; feeds signed overflow on the top slice.
    assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/addsub_pipe_n.sv
// rtl/addsub_pipe_n.sv - pipelined segmented-carry add/sub with flags, saturation and valid/ready
module addsub_pipe_n
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_ctrl,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG = seg_w(WIDTH, STAGES);

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
            $error("addsub_pipe_n: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Stage k reads *_cur[k] (operands entering stage k) and produces *_d[k] into *_q[k].
    // The last stage register doubles as the output register.
    stage_ctl_t       ctl_cur [STAGES];
    logic [WIDTH-1:0] a_cur   [STAGES];
    logic [WIDTH-1:0] bb_cur  [STAGES];
    logic [WIDTH-1:0] sum_cur [STAGES];

    stage_ctl_t       ctl_d   [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bb_d    [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];

    stage_ctl_t       ctl_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bb_q    [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];

    logic [SEG-1:0]   seg_s   [STAGES];
    logic             seg_co  [STAGES];
    logic             seg_cm  [STAGES];

    logic ovf_d, ovf_q;
    logic zero_d, zero_q;
    logic adv;
    logic sub_op;

    assign sub_op   = (add_ctrl == OP_SUB);
    assign adv      = !ctl_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign ctl_cur[0] = '{valid:  in_valid,
                                      a_sign: a[WIDTH-1],
                                      sat:    sat & SAT_EN,
                                      carry:  sub_op};
                assign a_cur[0]   = a;
                assign bb_cur[0]  = b ^ {WIDTH{sub_op}};
                assign sum_cur[0] = '0;
            end else begin : g_body
                assign ctl_cur[k] = ctl_q[k-1];
                assign a_cur[k]   = a_q[k-1];
                assign bb_cur[k]  = bb_q[k-1];
                assign sum_cur[k] = sum_q[k-1];
            end

            addsub_seg #(.W(SEG)) u_seg (
                .a     (a_cur[k][k*SEG +: SEG]),
                .b     (bb_cur[k][k*SEG +: SEG]),
                .cin   (ctl_cur[k].carry),
                .s     (seg_s[k]),
                .cout  (seg_co[k]),
                .c_msb (seg_cm[k])
            );
        end
    endgenerate

    // Next stage contents: insert each slice result, forward carry, then flags and saturation at the end.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctl_d[k]                  = ctl_cur[k];
            ctl_d[k].carry            = seg_co[k];
            a_d[k]                    = a_cur[k];
            bb_d[k]                   = bb_cur[k];
            sum_d[k]                  = sum_cur[k];
            sum_d[k][k*SEG +: SEG]    = seg_s[k];
        end
        ovf_d = seg_co[STAGES-1] ^ seg_cm[STAGES-1];
        if (ctl_cur[STAGES-1].sat && ovf_d) begin
            sum_d[STAGES-1] = ctl_cur[STAGES-1].a_sign ? {1'b1, {(WIDTH-1){1'b0}}}
                                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
        zero_d = ctl_cur[STAGES-1].valid && (sum_d[STAGES-1] == '0);
    end

    // All stages shift together on advance; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= ctl_d[k];
                a_q[k]   <= a_d[k];
                bb_q[k]  <= bb_d[k];
                sum_q[k] <= sum_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign sum       = sum_q[STAGES-1];
    assign c_out     = ctl_q[STAGES-1].carry;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
